// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_SUM_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input bit, reset to RST_VAL.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid / frame-error strobes.
// Optional running byte sum on o_sum when UART_RX_SUM_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned cycles_per_bit = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_serial,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_frame_err,
  output logic                   o_idle
`ifdef UART_RX_SUM_EN
  ,
  output logic [UART_SUM_W-1:0]  o_sum
`endif
);

  localparam int unsigned HALF  = cycles_per_bit / 2;
  localparam int unsigned CNT_W = $clog2(cycles_per_bit);

  rx_state_t              state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [2:0]             bit_idx, bit_nxt;
  logic [UART_DATA_W-1:0] shift, shift_nxt;
  logic [UART_DATA_W-1:0] data_nxt;
  logic                   valid_nxt, ferr_nxt;
  logic                   syncd;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_serial),
    .q   (syncd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_nxt;
      shift       <= shift_nxt;
      o_data      <= data_nxt;
      o_valid     <= valid_nxt;
      o_frame_err <= ferr_nxt;
    end
  end

  // Next-state: START waits HALF+1 clocks, DATA/STOP sample once per bit period
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = o_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!syncd) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_W'(HALF)) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = syncd ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_W'(cycles_per_bit - 1)) begin
          cnt_nxt   = '0;
          shift_nxt = {syncd, shift[UART_DATA_W-1:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_W'(cycles_per_bit - 1)) begin
          cnt_nxt = '0;
          if (syncd) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BREAK: begin
        // Held-low line must return high before a new start bit is accepted
        if (syncd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_idle = (state == IDLE);

`ifdef UART_RX_SUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sum <= '0;
    end else if (valid_nxt) begin
      o_sum <= o_sum + UART_SUM_W'(data_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a queue model.
module tb_uart_rx;

  localparam int unsigned CPB  = 3;
  localparam int unsigned HALF = CPB / 2;
  localparam int          LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_serial;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_idle;
`ifdef UART_RX_SUM_EN
  logic [31:0] o_sum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  rx_q[$];
  int          ferr_cnt = 0;
  int          both_cnt = 0;
  int          double_cnt = 0;
  int          valid_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ferr = 1'b0;
  logic [31:0] exp_sum = 0;

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_serial    (i_serial),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_idle      (o_idle)
`ifdef UART_RX_SUM_EN
    ,
    .o_sum       (o_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: collects received bytes and strobe anomalies
  always @(negedge clk) begin
    if (o_valid) begin
      rx_q.push_back(o_data);
      valid_cyc = cyc;
    end
    if (o_frame_err) ferr_cnt++;
    if (o_valid && o_frame_err) both_cnt++;
    if ((o_valid && prev_valid) || (o_frame_err && prev_ferr)) double_cnt++;
    prev_valid = o_valid;
    prev_ferr  = o_frame_err;
  end

  // Called at a negedge; leaves the line at `level` for one bit period
  task automatic send_bit(input logic level);
    i_serial = level;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
    start_cyc = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle_line(input int n);
    i_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_serial = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_data !== 8'h00 || o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b ferr=%b idle=%b required 00 0 0 1",
               o_data, o_valid, o_frame_err, o_idle);
    end
`ifdef UART_RX_SUM_EN
    checks++;
    if (o_sum !== 32'h0) begin
      errors++;
      $display("FAIL reset_sum: got %h required 00000000", o_sum);
    end
`endif
    rst = 1'b0;
    idle_line(4);
  endtask

  task automatic test_basic;
    int st;
    int f0;
    rx_q.delete();
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, st);
    idle_line(10);
    exp_sum += 32'h55;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL basic_data: got %0d bytes first=%h required 1 byte 55",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    checks++;
    if (valid_cyc - st != LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", valid_cyc - st, LAT);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL basic_ferr: got %0d strobes required 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch;
    int  f0;
    int  n0;
    logic busy;
    f0 = ferr_cnt;
    n0 = rx_q.size();
    busy = 1'b0;
    i_serial = 1'b0;
    @(negedge clk);
    i_serial = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!o_idle) busy = 1'b1;
    end
    checks++;
    if (o_idle !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_idle: idle=%b left_idle=%b required 1 1", o_idle, busy);
    end
    idle_line(10);
    checks++;
    if (rx_q.size() != n0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL glitch_strobes: valid=%0d ferr=%0d required 0 0", rx_q.size() - n0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err;
    int st;
    int f0;
    int n0;
    f0 = ferr_cnt;
    n0 = rx_q.size();
    send_frame(8'hA5, 1'b0, st);
    repeat (20) @(negedge clk);
    checks++;
    if (ferr_cnt != f0 + 1 || rx_q.size() != n0) begin
      errors++;
      $display("FAIL ferr_strobes: ferr=%0d valid=%0d required 1 0", ferr_cnt - f0, rx_q.size() - n0);
    end
    checks++;
    if (o_idle !== 1'b0) begin
      errors++;
      $display("FAIL ferr_held_low_idle: got %b required 0", o_idle);
    end
    checks++;
    if (o_data !== 8'h55) begin
      errors++;
      $display("FAIL ferr_data_hold: got %h required 55", o_data);
    end
    idle_line(6);
    checks++;
    if (o_idle !== 1'b1) begin
      errors++;
      $display("FAIL ferr_release_idle: got %b required 1", o_idle);
    end
`ifdef UART_RX_SUM_EN
    checks++;
    if (o_sum !== exp_sum) begin
      errors++;
      $display("FAIL ferr_sum: got %h required %h", o_sum, exp_sum);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int st;
    // Start from zero so the 0x48 + 0x69 sum is directly observable
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_sum = 0;
    idle_line(4);
    rx_q.delete();
    send_frame(8'h48, 1'b1, st);
    send_frame(8'h69, 1'b1, st);
    idle_line(10);
    exp_sum += 32'h48 + 32'h69;
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h48 || rx_q[1] !== 8'h69) begin
      errors++;
      $display("FAIL b2b_data: got %0d bytes required 48 69", rx_q.size());
    end
`ifdef UART_RX_SUM_EN
    checks++;
    if (o_sum !== 32'h000000B1) begin
      errors++;
      $display("FAIL b2b_sum: got %h required 000000b1", o_sum);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int st;
    logic [7:0] b;
    b = 8'h3C;
    i_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    i_serial = b[4];
    @(negedge clk);
    rst = 1'b1;
    i_serial = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_data !== 8'h00 || o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_idle !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: data=%h valid=%b ferr=%b idle=%b required 00 0 0 1",
               o_data, o_valid, o_frame_err, o_idle);
    end
`ifdef UART_RX_SUM_EN
    checks++;
    if (o_sum !== 32'h0) begin
      errors++;
      $display("FAIL midreset_sum: got %h required 00000000", o_sum);
    end
`endif
    exp_sum = 0;
    @(negedge clk);
    rst = 1'b0;
    idle_line(4);
    rx_q.delete();
    send_frame(8'h7E, 1'b1, st);
    idle_line(10);
    exp_sum += 32'h7E;
    checks++;
    if (rx_q.size() != 1 || o_data !== 8'h7E) begin
      errors++;
      $display("FAIL midreset_resend: bytes=%0d data=%h required 1 7e", rx_q.size(), o_data);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    int exp_ferr;
    int f0;
    int st;
    logic [7:0] b;
    logic good;
    exp_ferr = 0;
    f0 = ferr_cnt;
    rx_q.delete();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good, st);
      if (good) begin
        exp_q.push_back(b);
        exp_sum += {24'h0, b};
        if ($urandom_range(0, 1) == 1) idle_line($urandom_range(1, 2 * CPB));
      end else begin
        exp_ferr++;
        idle_line(CPB * $urandom_range(1, 3));
      end
    end
    idle_line(12);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_byte[%0d]: got %h required %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ferr_cnt - f0 != exp_ferr) begin
      errors++;
      $display("FAIL rand_ferr: got %0d required %0d", ferr_cnt - f0, exp_ferr);
    end
`ifdef UART_RX_SUM_EN
    checks++;
    if (o_sum !== exp_sum) begin
      errors++;
      $display("FAIL rand_sum: got %h required %h", o_sum, exp_sum);
    end
`endif
  endtask

  task automatic test_strobe_rules;
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d cycles required 0", both_cnt);
    end
    checks++;
    if (double_cnt != 0) begin
      errors++;
      $display("FAIL strobe_width: got %0d multi-cycle strobes required 0", double_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_serial = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
